// File: rtl/wr_demux_1to2.sv
// -----------------------------------------------------------------------------
// wr_demux_1to2
//   AXI3 write-request router: one master, two slaves.
//   The AW beat is decoded against two address windows. A hit is forwarded
//   (registered) to the selected slave, and the W beats that follow are then
//   passed through combinationally to that slave until WLAST. A miss is
//   absorbed locally: W beats are sunk and a DECERR response is raised on the
//   err port, which feeds a third input of the B-response mux.
//   Only one write (AW + its W burst) is in flight at a time. B responses
//   from the slaves do not pass through this block.
//
// Ports
//   aclk, areset           clock, synchronous active-low reset
//   aw*_m / w*_m           master AW and W channels (inputs + ready outputs)
//   aw*_s1 / aw*_s2        AW channel to slave 1 / 2 (payload from AW latch)
//   w*_s1 / w*_s2          W channel to slave 1 / 2 (payload pass-through)
//   bid_err, bresp_err,
//   bvalid_err, bready_err DECERR response for unmapped writes
//   len_err                1-cycle pulse after a WLAST whose beat count
//                          differs from awlen+1
//   dbg_state              current FSM state
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A valid, once raised, holds its payload stable until that edge.
// -----------------------------------------------------------------------------
module wr_demux_1to2 #(
   parameter logic [31:0] S1_BASE  = 32'h0000_0000,
   parameter logic [31:0] S2_BASE  = 32'h1000_0000,
   parameter logic [31:0] DEC_MASK = 32'hF000_0000
) (
   input  logic        aclk,
   input  logic        areset,
   // master AW
   input  logic [3:0]  awid_m,
   input  logic [31:0] awaddr_m,
   input  logic [3:0]  awlen_m,
   input  logic [2:0]  awsize_m,
   input  logic [1:0]  awburst_m,
   input  logic        awvalid_m,
   output logic        awready_m,
   // master W
   input  logic [3:0]  wid_m,
   input  logic [31:0] wdata_m,
   input  logic [3:0]  wstrb_m,
   input  logic        wlast_m,
   input  logic        wvalid_m,
   output logic        wready_m,
   // slave 1 AW
   output logic [3:0]  awid_s1,
   output logic [31:0] awaddr_s1,
   output logic [3:0]  awlen_s1,
   output logic [2:0]  awsize_s1,
   output logic [1:0]  awburst_s1,
   output logic        awvalid_s1,
   input  logic        awready_s1,
   // slave 1 W
   output logic [3:0]  wid_s1,
   output logic [31:0] wdata_s1,
   output logic [3:0]  wstrb_s1,
   output logic        wlast_s1,
   output logic        wvalid_s1,
   input  logic        wready_s1,
   // slave 2 AW
   output logic [3:0]  awid_s2,
   output logic [31:0] awaddr_s2,
   output logic [3:0]  awlen_s2,
   output logic [2:0]  awsize_s2,
   output logic [1:0]  awburst_s2,
   output logic        awvalid_s2,
   input  logic        awready_s2,
   // slave 2 W
   output logic [3:0]  wid_s2,
   output logic [31:0] wdata_s2,
   output logic [3:0]  wstrb_s2,
   output logic        wlast_s2,
   output logic        wvalid_s2,
   input  logic        wready_s2,
   // local DECERR response
   output logic [3:0]  bid_err,
   output logic [1:0]  bresp_err,
   output logic        bvalid_err,
   input  logic        bready_err,
   // status
   output logic        len_err,
   output logic [2:0]  dbg_state
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_AW_FWD   = 3'd1,
      ST_W_FWD    = 3'd2,
      ST_W_SINK   = 3'd3,
      ST_ERR_RESP = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  awid_q, awid_d;
   logic [31:0] awaddr_q, awaddr_d;
   logic [3:0]  awlen_q, awlen_d;
   logic [2:0]  awsize_q, awsize_d;
   logic [1:0]  awburst_q, awburst_d;
   logic        sel_q, sel_d;          // 0: slave 1, 1: slave 2
   logic [4:0]  beat_cnt_q, beat_cnt_d;
   logic        len_err_q, len_err_d;
   // Keeps awready_m low while reset is held and for the release edge itself.
   logic        rdy_en_q, rdy_en_d;

   logic        hit1, hit2;
   logic        aw_hs, w_hs;
   logic [4:0]  beat_inc;
   logic [4:0]  beats_exp;

   assign hit1  = (awaddr_m & DEC_MASK) == S1_BASE;
   assign hit2  = (awaddr_m & DEC_MASK) == S2_BASE;
   assign aw_hs = awvalid_m & awready_m;
   assign w_hs  = wvalid_m & wready_m;

   // Saturate rather than wrap so an overlong burst can never alias back
   // onto a legal count.
   assign beat_inc  = (beat_cnt_q == 5'd31) ? 5'd31 : beat_cnt_q + 5'd1;
   assign beats_exp = {1'b0, awlen_q} + 5'd1;

   // Output decode
   always_comb begin
      awready_m  = 1'b0;
      wready_m   = 1'b0;
      awvalid_s1 = 1'b0;
      awvalid_s2 = 1'b0;
      wvalid_s1  = 1'b0;
      wvalid_s2  = 1'b0;
      bvalid_err = 1'b0;
      bid_err    = 4'd0;
      bresp_err  = 2'b00;
      case (state_q)
         ST_IDLE: begin
            awready_m = rdy_en_q;
         end
         ST_AW_FWD: begin
            awvalid_s1 = ~sel_q;
            awvalid_s2 = sel_q;
         end
         ST_W_FWD: begin
            wvalid_s1 = wvalid_m & ~sel_q;
            wvalid_s2 = wvalid_m & sel_q;
            wready_m  = sel_q ? wready_s2 : wready_s1;
         end
         ST_W_SINK: begin
            wready_m = 1'b1;
         end
         ST_ERR_RESP: begin
            bvalid_err = 1'b1;
            bid_err    = awid_q;
            bresp_err  = 2'b11;
         end
         default: begin
         end
      endcase
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      awid_d     = awid_q;
      awaddr_d   = awaddr_q;
      awlen_d    = awlen_q;
      awsize_d   = awsize_q;
      awburst_d  = awburst_q;
      sel_d      = sel_q;
      beat_cnt_d = beat_cnt_q;
      len_err_d  = 1'b0;
      rdy_en_d   = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (aw_hs) begin
               awid_d     = awid_m;
               awaddr_d   = awaddr_m;
               awlen_d    = awlen_m;
               awsize_d   = awsize_m;
               awburst_d  = awburst_m;
               sel_d      = ~hit1;       // slave 1 wins if both windows hit
               beat_cnt_d = 5'd0;
               state_d    = (hit1 | hit2) ? ST_AW_FWD : ST_W_SINK;
            end
         end
         ST_AW_FWD: begin
            if (sel_q ? awready_s2 : awready_s1) begin
               state_d = ST_W_FWD;
            end
         end
         ST_W_FWD, ST_W_SINK: begin
            if (w_hs) begin
               beat_cnt_d = beat_inc;
               if (wlast_m) begin
                  len_err_d = (beat_inc != beats_exp);
                  state_d   = (state_q == ST_W_FWD) ? ST_IDLE : ST_ERR_RESP;
               end
            end
         end
         ST_ERR_RESP: begin
            if (bready_err) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!areset) begin
         state_q    <= ST_IDLE;
         awid_q     <= 4'd0;
         awaddr_q   <= 32'd0;
         awlen_q    <= 4'd0;
         awsize_q   <= 3'd0;
         awburst_q  <= 2'd0;
         sel_q      <= 1'b0;
         beat_cnt_q <= 5'd0;
         len_err_q  <= 1'b0;
         rdy_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         awid_q     <= awid_d;
         awaddr_q   <= awaddr_d;
         awlen_q    <= awlen_d;
         awsize_q   <= awsize_d;
         awburst_q  <= awburst_d;
         sel_q      <= sel_d;
         beat_cnt_q <= beat_cnt_d;
         len_err_q  <= len_err_d;
         rdy_en_q   <= rdy_en_d;
      end
   end

   // AW payload comes from the latch; both slaves see it, only one gets valid.
   assign awid_s1    = awid_q;
   assign awaddr_s1  = awaddr_q;
   assign awlen_s1   = awlen_q;
   assign awsize_s1  = awsize_q;
   assign awburst_s1 = awburst_q;
   assign awid_s2    = awid_q;
   assign awaddr_s2  = awaddr_q;
   assign awlen_s2   = awlen_q;
   assign awsize_s2  = awsize_q;
   assign awburst_s2 = awburst_q;

   // W payload is a straight pass-through; wvalid does the steering.
   assign wid_s1   = wid_m;
   assign wdata_s1 = wdata_m;
   assign wstrb_s1 = wstrb_m;
   assign wlast_s1 = wlast_m;
   assign wid_s2   = wid_m;
   assign wdata_s2 = wdata_m;
   assign wstrb_s2 = wstrb_m;
   assign wlast_s2 = wlast_m;

   assign len_err   = len_err_q;
   assign dbg_state = state_q;

endmodule
